// File: rtl/flag_branch_unit.sv
// N/V/Z flag register plus a single-outstanding conditional branch resolver.
// Stalls on in-flight flag producers and holds a front-end flush window after taken branches.
module flag_branch_unit #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  alu_flag,
    input  logic [2:0]  flag_we,
    input  logic        alu_busy,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  br_cond,
    input  logic [15:0] br_target,
    input  logic [15:0] br_fallthru,
    output logic        br_done,
    output logic        br_taken,
    output logic [15:0] redirect_pc,
    output logic        flush,
    output logic [2:0]  flag_q
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] CC_ALWAYS  = 3'b111;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [2:0]  cond_q;
    logic [15:0] target_q;
    logic [15:0] fallthru_q;

    logic [2:0]  flag_d;
    logic        accept;
    logic        stall_now;
    logic        eval_now;
    logic        taken_now;
    logic [2:0]  eval_cond;
    logic [15:0] eval_target;
    logic [15:0] eval_fallthru;

    // Flags are ordered {N, V, Z}.
    function automatic logic cond_met(input logic [2:0] ccc, input logic [2:0] f);
        logic n;
        logic v;
        logic z;
        logic res;
        n = f[2];
        v = f[1];
        z = f[0];
        case (ccc)
            3'b000:  res = !z;
            3'b001:  res = z;
            3'b010:  res = !z && !n;
            3'b011:  res = n;
            3'b100:  res = z || (!z && !n);
            3'b101:  res = n || z;
            3'b110:  res = v;
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    always_comb begin
        // Same-cycle flag writes are forwarded into the evaluation.
        flag_d        = (flag_we & alu_flag) | (~flag_we & flag_q);
        br_ready      = (state_q == ST_IDLE) && !rst;
        accept        = br_valid && br_ready;
        stall_now     = 1'b0;
        eval_now      = 1'b0;
        eval_cond     = br_cond;
        eval_target   = br_target;
        eval_fallthru = br_fallthru;
        if (state_q == ST_IDLE) begin
            if (accept) begin
                if (alu_busy && (br_cond != CC_ALWAYS)) begin
                    stall_now = 1'b1;
                end else begin
                    eval_now = 1'b1;
                end
            end
        end else if (state_q == ST_WAIT) begin
            eval_cond     = cond_q;
            eval_target   = target_q;
            eval_fallthru = fallthru_q;
            eval_now      = !alu_busy;
        end
        taken_now = cond_met(eval_cond, flag_d);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cond_q     <= br_cond;
            target_q   <= br_target;
            fallthru_q <= br_fallthru;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flag_q      <= 3'b000;
            cnt_q       <= 3'd0;
            br_done     <= 1'b0;
            br_taken    <= 1'b0;
            redirect_pc <= 16'h0000;
            flush       <= 1'b0;
        end else begin
            flag_q  <= flag_d;
            br_done <= eval_now;
            if (eval_now) begin
                br_taken    <= taken_now;
                redirect_pc <= taken_now ? eval_target : eval_fallthru;
            end
            case (state_q)
                ST_IDLE: begin
                    if (stall_now) begin
                        state_q <= ST_WAIT;
                    end else if (eval_now && taken_now) begin
                        state_q <= ST_FLUSH;
                        flush   <= 1'b1;
                        cnt_q   <= FLUSH_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (eval_now) begin
                        if (taken_now) begin
                            state_q <= ST_FLUSH;
                            flush   <= 1'b1;
                            cnt_q   <= FLUSH_LOAD;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= ST_IDLE;
                        flush   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    flush   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Self-checking bench for flag_branch_unit: vector table, directed corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_flag_branch_unit;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  alu_flag;
    logic [2:0]  flag_we;
    logic        alu_busy;
    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_cond;
    logic [15:0] br_target;
    logic [15:0] br_fallthru;
    logic        br_done;
    logic        br_taken;
    logic [15:0] redirect_pc;
    logic        flush;
    logic [2:0]  flag_q;

    always #5 clk = ~clk;

    flag_branch_unit #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .alu_flag(alu_flag), .flag_we(flag_we), .alu_busy(alu_busy),
        .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_target(br_target),
        .br_fallthru(br_fallthru), .br_done(br_done), .br_taken(br_taken),
        .redirect_pc(redirect_pc), .flush(flush), .flag_q(flag_q)
    );

    typedef struct {
        logic [2:0] flags;
        logic [2:0] cond;
        bit         taken;
    } vec_t;

    vec_t tbl[64];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Condition rules written straight from the N/V/Z definitions.
    function automatic bit ref_taken(input logic [2:0] c, input logic [2:0] f);
        bit n;
        bit v;
        bit z;
        n = f[2];
        v = f[1];
        z = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic do_reset();
        rst      = 1'b1;
        br_valid = 1'b0;
        #1;
        chk("ready_during_rst", 32'(br_ready), 32'd0);
        step();
        chk("rst_done", 32'(br_done), 32'd0);
        chk("rst_taken", 32'(br_taken), 32'd0);
        chk("rst_pc", 32'(redirect_pc), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_flag", 32'(flag_q), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(br_ready), 32'd1);
    endtask

    task automatic drain_flush(input string name);
        int fc;
        fc = 0;
        while (flush && fc < 10) begin
            fc++;
            step();
        end
        chk(name, 32'(fc), 32'(FC));
        chk({name, "_ready"}, 32'(br_ready), 32'd1);
    endtask

    task automatic set_flags(input logic [2:0] f);
        flag_we  = 3'b111;
        alu_flag = f;
        step();
        flag_we  = 3'b000;
    endtask

    // Reference model state
    logic [2:0]  m_flags;
    bit          m_pend;
    logic [2:0]  m_cond;
    logic [15:0] m_tgt;
    logic [15:0] m_ft;
    int          m_fl;
    bit          m_done;
    bit          m_taken;
    logic [15:0] m_pc;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; alu_flag = 3'b0; flag_we = 3'b0; alu_busy = 1'b0;
        br_valid = 1'b0; br_cond = 3'b0; br_target = 16'h0; br_fallthru = 16'h0;
        step();
        do_reset();

        // Flag masking
        alu_flag = 3'b111; flag_we = 3'b001;
        step();
        chk("mask_z_only", 32'(flag_q), 32'd1);
        alu_flag = 3'b000; flag_we = 3'b110;
        step();
        chk("mask_hold", 32'(flag_q), 32'd1);
        flag_we = 3'b000;
        chk("example_100_lt", 32'(ref_taken(3'b011, 3'b100)), 32'd1);

        for (int i = 0; i < 64; i++) begin
            tbl[i].flags = 3'(i / 8);
            tbl[i].cond  = 3'(i % 8);
            tbl[i].taken = ref_taken(3'(i % 8), 3'(i / 8));
        end

        for (int i = 0; i < 64; i++) begin
            set_flags(tbl[i].flags);
            chk("tbl_flag", 32'(flag_q), 32'(tbl[i].flags));
            br_valid = 1'b1; br_cond = tbl[i].cond;
            br_target = 16'h1234; br_fallthru = 16'h0042; alu_busy = 1'b0;
            step();
            br_valid = 1'b0;
            chk("tbl_done", 32'(br_done), 32'd1);
            chk("tbl_taken", 32'(br_taken), 32'(tbl[i].taken));
            chk("tbl_pc", 32'(redirect_pc), tbl[i].taken ? 32'h1234 : 32'h0042);
            if (tbl[i].taken) begin
                drain_flush("tbl_flush_len");
            end else begin
                chk("tbl_nt_flush", 32'(flush), 32'd0);
                chk("tbl_nt_ready", 32'(br_ready), 32'd1);
            end
        end

        // Forwarding of a same-cycle Z write into an EQ branch
        do_reset();
        flag_we = 3'b001; alu_flag = 3'b001;
        br_valid = 1'b1; br_cond = 3'b001; br_target = 16'hA000; br_fallthru = 16'h0002;
        step();
        br_valid = 1'b0; flag_we = 3'b000;
        chk("fwd_done", 32'(br_done), 32'd1);
        chk("fwd_taken", 32'(br_taken), 32'd1);
        chk("fwd_flag", 32'(flag_q), 32'd1);
        drain_flush("fwd_flush");

        // Stall: EQ with alu_busy for 3 cycles, Z written as busy drops
        set_flags(3'b000);
        br_valid = 1'b1; br_cond = 3'b001; br_target = 16'h2222; br_fallthru = 16'h0044;
        alu_busy = 1'b1;
        step();
        br_cond = 3'b000; br_target = 16'hBEEF; br_fallthru = 16'hDEAD;
        for (int i = 0; i < 2; i++) begin
            chk("stall_ready", 32'(br_ready), 32'd0);
            chk("stall_no_done", 32'(br_done), 32'd0);
            step();
        end
        alu_busy = 1'b0; flag_we = 3'b001; alu_flag = 3'b001;
        #1;
        chk("stall_ready_last", 32'(br_ready), 32'd0);
        step();
        br_valid = 1'b0; flag_we = 3'b000;
        chk("stall_done", 32'(br_done), 32'd1);
        chk("stall_taken", 32'(br_taken), 32'd1);
        chk("stall_pc", 32'(redirect_pc), 32'h2222);
        drain_flush("stall_flush");

        // Always-taken ignores alu_busy
        br_valid = 1'b1; br_cond = 3'b111; br_target = 16'h3333; alu_busy = 1'b1;
        step();
        br_valid = 1'b0; alu_busy = 1'b0;
        chk("al_done", 32'(br_done), 32'd1);
        chk("al_pc", 32'(redirect_pc), 32'h3333);
        drain_flush("al_flush");

        // Flush window with br_valid held high
        br_valid = 1'b1; br_cond = 3'b111; br_target = 16'h4444;
        step();
        br_target = 16'h5555;
        chk("fw1_done", 32'(br_done), 32'd1);
        chk("fw1_flush", 32'(flush), 32'd1);
        chk("fw1_ready", 32'(br_ready), 32'd0);
        step();
        chk("fw2_done", 32'(br_done), 32'd0);
        chk("fw2_flush", 32'(flush), 32'd1);
        chk("fw2_ready", 32'(br_ready), 32'd0);
        step();
        chk("fw3_flush", 32'(flush), 32'd0);
        chk("fw3_ready", 32'(br_ready), 32'd1);
        chk("fw3_done", 32'(br_done), 32'd0);
        step();
        br_valid = 1'b0;
        chk("fw4_done", 32'(br_done), 32'd1);
        chk("fw4_pc", 32'(redirect_pc), 32'h5555);
        drain_flush("fw4_flush");

        // Back-to-back not-taken branches
        set_flags(3'b001);
        br_valid = 1'b1; br_cond = 3'b000; br_target = 16'h9999; br_fallthru = 16'h0100;
        step();
        br_fallthru = 16'h0200;
        chk("nt1_done", 32'(br_done), 32'd1);
        chk("nt1_taken", 32'(br_taken), 32'd0);
        chk("nt1_pc", 32'(redirect_pc), 32'h0100);
        chk("nt1_flush", 32'(flush), 32'd0);
        chk("nt1_ready", 32'(br_ready), 32'd1);
        step();
        br_valid = 1'b0;
        chk("nt2_done", 32'(br_done), 32'd1);
        chk("nt2_pc", 32'(redirect_pc), 32'h0200);
        chk("nt2_flush", 32'(flush), 32'd0);
        step();
        chk("nt3_done", 32'(br_done), 32'd0);

        // Reset while waiting
        set_flags(3'b000);
        br_valid = 1'b1; br_cond = 3'b001; br_target = 16'h7777; alu_busy = 1'b1;
        step();
        br_valid = 1'b0; alu_busy = 1'b0;
        chk("rw_ready", 32'(br_ready), 32'd0);
        do_reset();
        step();
        chk("rw_no_done", 32'(br_done), 32'd0);

        // Reset during flush
        br_valid = 1'b1; br_cond = 3'b111; br_target = 16'h6666;
        step();
        br_valid = 1'b0;
        chk("rf_flush", 32'(flush), 32'd1);
        chk("rf_pc", 32'(redirect_pc), 32'h6666);
        do_reset();
        step();
        chk("rf_flush_after", 32'(flush), 32'd0);
        chk("rf_no_done", 32'(br_done), 32'd0);

        // Randomized run against the reference model
        do_reset();
        m_flags = 3'b000; m_pend = 1'b0; m_fl = 0;
        m_taken = 1'b0; m_pc = 16'h0; m_cond = 3'b0; m_tgt = 16'h0; m_ft = 16'h0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic [2:0] eff;
            bit         exp_ready;
            bit         ev;
            logic [2:0] ec;
            logic [15:0] et;
            logic [15:0] ef;
            rst         = ($urandom_range(0, 49) == 0);
            br_valid    = 1'($urandom_range(0, 1));
            br_cond     = 3'($urandom);
            br_target   = 16'($urandom);
            br_fallthru = 16'($urandom);
            alu_busy    = ($urandom_range(0, 2) == 0);
            flag_we     = 3'($urandom);
            alu_flag    = 3'($urandom);
            #1;
            exp_ready = !rst && !m_pend && (m_fl == 0);
            chk("rnd_ready", 32'(br_ready), 32'(exp_ready));
            eff = (flag_we & alu_flag) | (~flag_we & m_flags);
            if (rst) begin
                m_flags = 3'b000; m_pend = 1'b0; m_fl = 0;
                m_done = 1'b0; m_taken = 1'b0; m_pc = 16'h0;
            end else begin
                ev = 1'b0; ec = br_cond; et = br_target; ef = br_fallthru;
                if (m_fl > 0) m_fl--;
                if (exp_ready && br_valid) begin
                    if (alu_busy && br_cond != 3'b111) begin
                        m_pend = 1'b1; m_cond = br_cond; m_tgt = br_target; m_ft = br_fallthru;
                    end else begin
                        ev = 1'b1;
                    end
                end else if (m_pend && !alu_busy) begin
                    ev = 1'b1; ec = m_cond; et = m_tgt; ef = m_ft; m_pend = 1'b0;
                end
                m_done = ev;
                if (ev) begin
                    m_taken = ref_taken(ec, eff);
                    m_pc    = m_taken ? et : ef;
                    if (m_taken) m_fl = FC;
                end
                m_flags = eff;
            end
            step();
            chk("rnd_done", 32'(br_done), 32'(m_done));
            chk("rnd_taken", 32'(br_taken), 32'(m_taken));
            chk("rnd_pc", 32'(redirect_pc), 32'(m_pc));
            chk("rnd_flush", 32'(flush), 32'(m_fl > 0));
            chk("rnd_flag", 32'(flag_q), 32'(m_flags));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Holds the processor's N/V/Z flag register, fed by the 16-bit add/sub unit's `flag` output, and resolves conditional branches against it. It accepts one branch request at a time over a valid/ready handshake. It stalls while a flag-producing instruction is still in flight, registers the taken/not-taken outcome and target PC, and holds a flush window for the front end after a taken branch.

## Interface
- `FLUSH_CYCLES`, default 2: cycles `flush` stays high after a taken branch; legal range 1..7.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `alu_flag`  in  3  {N, V, Z} from add/sub unit: [2]=sign, [1]=overflow, [0]=zero.
- `flag_we`  in  3  per-bit write mask for `alu_flag` (same bit order); 0 = hold.
- `alu_busy`  in  1  a flag-writing instruction is in flight and not yet written.
- `br_valid`  in  1  branch request present.
- `br_ready`  out  1  unit can accept a request.
- `br_cond`  in  3  condition code ccc.
- `br_target`  in  16  taken PC.
- `br_fallthru`  in  16  not-taken PC (PC+2).
- `br_done`  out  1  one-cycle pulse: outcome valid.
- `br_taken`  out  1  outcome; valid when `br_done`=1.
- `redirect_pc`  out  16  `br_target` if taken, else `br_fallthru`; valid with `br_done`.
- `flush`  out  1  front-end flush window after a taken branch.
- `flag_q`  out  3  current flag register {N, V, Z}.

## Operation
- **Flag register:**
  - Each cycle, every bit i with `flag_we[i]`=1 loads `alu_flag[i]`.
  - Bits with `flag_we[i]`=0 hold their value.
- **Effective flags** for evaluation are merged combinationally: `flag_we[i] ? alu_flag[i] : flag_q[i]`. A same-cycle write is therefore forwarded into the evaluation.
- **Conditions** (N, V, Z taken from the effective flags):
  - 000 NE: Z=0.
  - 001 EQ: Z=1.
  - 010 GT: Z=0 & N=0.
  - 011 LT: N=1.
  - 100 GE: Z=1 | (Z=0 & N=0).
  - 101 LE: N=1 | Z=1.
  - 110 OV: V=1.
  - 111: always taken.
- **Acceptance:**
  - A request is accepted when `br_valid` & `br_ready`.
  - `br_cond`, `br_target` and `br_fallthru` are latched on acceptance.
  - Inputs are ignored while `br_ready`=0.
- **FSM states:**
  - IDLE:
    - `br_ready`=1.
    - On accept with `alu_busy`=0, or with cond=111: evaluate this cycle and stay IDLE, or go to FLUSH if taken.
    - On accept with `alu_busy`=1 and cond≠111: go to WAIT.
  - WAIT:
    - `br_ready`=0.
    - Each cycle with `alu_busy`=0: evaluate using the effective flags, then go to FLUSH if taken, else IDLE.
    - Otherwise stay in WAIT.
  - FLUSH:
    - `br_ready`=0 and `flush`=1.
    - A 3-bit counter loads `FLUSH_CYCLES-1` on entry and decrements each cycle.
    - Go to IDLE after the cycle in which the counter reads 0.
- **Registered outcome:** an evaluation in cycle E produces `br_done`=1, `br_taken` and `redirect_pc` in cycle E+1. `br_done` is low in all other cycles.
- **Reset:**
  - `flag_q`=000; state IDLE.
  - `br_ready`=0 during the reset cycle and 1 afterwards.
  - `br_done`=0, `br_taken`=0, `redirect_pc`=0x0000, `flush`=0, counter=0.
  - Reset in WAIT or FLUSH abandons the branch; no `br_done` is produced.
- **Simultaneous events:**
  - A flag write and an evaluation in the same cycle: the evaluation uses the new flag values.
  - The register still updates at that edge.
  - Flag writes continue normally in every state.

## Timing
- Accept in cycle T with no stall: `br_done` at T+1.
  - Not taken: `br_ready`=1 again at T+1, so back-to-back branches are accepted every cycle.
  - Taken: `flush`=1 in T+1..T+FLUSH_CYCLES and `br_ready`=1 at T+FLUSH_CYCLES+1.
- Stall: if `alu_busy` falls to 0 in cycle W, `br_done` is at W+1.
- `flag_q` reflects a write one cycle after `flag_we` is sampled.
- `redirect_pc` and `br_taken` hold their last values until the next `br_done`.

## Test plan
- **Reset and flag masking.**
  - Stimulus: reset, then `alu_flag`=111 with `flag_we`=001.
  - Required: `flag_q`=001 next cycle.
  - Stimulus: `alu_flag`=000 with `flag_we`=110.
  - Required: `flag_q` stays 001.
- **All eight conditions.** For each of the 8 flag patterns × 8 ccc, issue a branch with `br_target`=0x1234, `br_fallthru`=0x0042, `alu_busy`=0.
  - Required: `br_done` one cycle later with `br_taken` per the condition list; `redirect_pc` 0x1234 if taken, else 0x0042.
  - Example: flags 100 with cond 011 is taken.
- **Forwarding.**
  - Stimulus: `flag_q`=000 with the same-cycle write `flag_we`=001, `alu_flag`=001, and an EQ branch.
  - Required: taken; `flag_q`=001 next cycle.
- **Stall.**
  - Stimulus: EQ branch accepted with `alu_busy`=1 for 3 cycles; flags are written Z=1 in the cycle `alu_busy` drops.
  - Required: `br_ready`=0 throughout the stall; `br_done`/taken the cycle after `alu_busy`=0.
  - Stimulus: cond 111 with `alu_busy`=1.
  - Required: no stall; `br_done` at T+1.
- **Flush window.**
  - Stimulus: taken branch with `FLUSH_CYCLES`=2.
  - Required: `flush` high for exactly 2 cycles; `br_valid` held high is accepted only at T+3.
  - Stimulus: a not-taken branch.
  - Required: `flush` never asserts and the next request is accepted at T+1.
- **Reset mid-operation.**
  - Stimulus: assert `rst` in WAIT, and separately in FLUSH.
  - Required: no `br_done`; all outputs take their reset values next cycle; `br_ready`=1 the cycle after `rst` deasserts.
